// File: rtl/pu_seq_pkg.sv
// pu_seq_pkg: shared constants and state encoding for the PU sequencer and its peers.
`default_nettype none

package pu_seq_pkg;

  localparam int DEF_WADDR_WIDTH = 7;
  localparam int DEF_CADDR_WIDTH = 5;
  localparam int DEF_MAC_LAT     = 2;
  localparam int BIAS_SEL_WIDTH  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/pu_seq_delay_line.sv
// pu_delay_line: DEPTH-stage shift register with asynchronous active-low clear.
`default_nettype none

module pu_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/pu_seq.sv
// pu_seq: steps one processing unit through a tile of P passes x N output positions.
`default_nettype none

module pu_seq
  import pu_seq_pkg::*;
#(
  parameter int WADDR_WIDTH = DEF_WADDR_WIDTH,
  parameter int CADDR_WIDTH = DEF_CADDR_WIDTH,
  parameter int MAC_LAT     = DEF_MAC_LAT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [WADDR_WIDTH-1:0]    cfg_num_pass,
  input  logic [CADDR_WIDTH:0]      cfg_num_out,
  input  logic [WADDR_WIDTH-1:0]    cfg_w_base,
  input  logic [WADDR_WIDTH-1:0]    cfg_r_base,
  input  logic [BIAS_SEL_WIDTH-1:0] cfg_bias_addr,
  input  logic                      cfg_add_bias,
  input  logic                      cfg_relu,
  output logic                      busy,
  output logic                      done,
  output logic                      data_req,
  output logic [WADDR_WIDTH-1:0]    w_rd_addr,
  output logic [BIAS_SEL_WIDTH-1:0] bias_addr,
  output logic                      add_bias,
  output logic                      relu,
  output logic                      last,
  output logic                      cache_clear,
  output logic [CADDR_WIDTH-1:0]    cache_rd_addr,
  output logic [CADDR_WIDTH-1:0]    cache_wr_addr,
  output logic                      r_wr_en,
  output logic [WADDR_WIDTH-1:0]    r_wr_addr
);

  localparam int DCNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DCNT_W-1:0]      DRAIN_LAST = DCNT_W'(MAC_LAT - 1);
  localparam logic [CADDR_WIDTH:0]   N_MAX      = {1'b1, {CADDR_WIDTH{1'b0}}};
  localparam logic [CADDR_WIDTH:0]   N_ONE      = (CADDR_WIDTH+1)'(1);
  localparam logic [WADDR_WIDTH-1:0] W_ONE      = WADDR_WIDTH'(1);
  localparam logic [CADDR_WIDTH-1:0] C_ONE      = CADDR_WIDTH'(1);
  localparam logic [DCNT_W-1:0]      D_ONE      = DCNT_W'(1);
  localparam int DL_W = 1 + CADDR_WIDTH + WADDR_WIDTH;

  seq_state_t state, state_nxt;

  logic [WADDR_WIDTH-1:0]    pass_q, w_base_q, r_base_q;
  logic [CADDR_WIDTH:0]      nout_q;
  logic [BIAS_SEL_WIDTH-1:0] bias_sel_q;
  logic                      add_bias_q, relu_q;

  logic [WADDR_WIDTH-1:0] p_cnt, p_nxt;
  logic [CADDR_WIDTH-1:0] o_cnt, o_nxt;
  logic [DCNT_W-1:0]      d_cnt, d_nxt;

  logic                   latch, step_nxt, busy_nxt, done_nxt, clear_nxt, last_nxt;
  logic [CADDR_WIDTH:0]   nout_in;
  logic                   p_last, o_last;
  logic [DL_W-1:0]        dl_in, dl_out;
  logic [WADDR_WIDTH-1:0] r_addr_in;

  assign nout_in = (cfg_num_out > N_MAX) ? N_MAX : cfg_num_out;
  assign p_last  = (p_cnt == pass_q - W_ONE);
  assign o_last  = ({1'b0, o_cnt} == nout_q - N_ONE);

  always_comb begin
    state_nxt = state;
    p_nxt     = p_cnt;
    o_nxt     = o_cnt;
    d_nxt     = d_cnt;
    latch     = 1'b0;
    step_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    clear_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          latch = 1'b1;
          if (cfg_num_pass == '0 || nout_in == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = ST_CLEAR;
            busy_nxt  = 1'b1;
            clear_nxt = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        state_nxt = ST_RUN;
        p_nxt     = '0;
        o_nxt     = '0;
        step_nxt  = 1'b1;
        busy_nxt  = 1'b1;
      end
      ST_RUN: begin
        busy_nxt = 1'b1;
        if (!o_last) begin
          o_nxt    = o_cnt + C_ONE;
          step_nxt = 1'b1;
        end else if (!p_last) begin
          p_nxt    = p_cnt + W_ONE;
          o_nxt    = '0;
          step_nxt = 1'b1;
        end else begin
          state_nxt = ST_DRAIN;
          d_nxt     = '0;
        end
      end
      ST_DRAIN: begin
        if (d_cnt == DRAIN_LAST) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          d_nxt    = d_cnt + D_ONE;
          busy_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    last_nxt = step_nxt && (p_nxt == pass_q - W_ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pass_q     <= '0;
      nout_q     <= '0;
      w_base_q   <= '0;
      r_base_q   <= '0;
      bias_sel_q <= '0;
      add_bias_q <= 1'b0;
      relu_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        pass_q     <= cfg_num_pass;
        nout_q     <= nout_in;
        w_base_q   <= cfg_w_base;
        r_base_q   <= cfg_r_base;
        bias_sel_q <= cfg_bias_addr;
        add_bias_q <= cfg_add_bias;
        relu_q     <= cfg_relu;
      end
    end
  end

  // Step outputs are built from the next-step counters so they appear registered in the step cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_cnt         <= '0;
      o_cnt         <= '0;
      d_cnt         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cache_clear   <= 1'b0;
      data_req      <= 1'b0;
      w_rd_addr     <= '0;
      bias_addr     <= '0;
      add_bias      <= 1'b0;
      relu          <= 1'b0;
      last          <= 1'b0;
      cache_rd_addr <= '0;
    end else begin
      p_cnt         <= p_nxt;
      o_cnt         <= o_nxt;
      d_cnt         <= d_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      cache_clear   <= clear_nxt;
      data_req      <= step_nxt;
      w_rd_addr     <= step_nxt ? w_base_q + p_nxt : '0;
      bias_addr     <= step_nxt ? bias_sel_q : '0;
      add_bias      <= step_nxt && add_bias_q && (p_nxt == '0);
      relu          <= last_nxt && relu_q;
      last          <= last_nxt;
      cache_rd_addr <= step_nxt ? o_nxt : '0;
    end
  end

  assign r_addr_in = data_req ? r_base_q + WADDR_WIDTH'(cache_rd_addr) : '0;
  assign dl_in     = {data_req & last, cache_rd_addr, r_addr_in};

  pu_delay_line #(
    .DEPTH (MAC_LAT),
    .WIDTH (DL_W)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dl_in),
    .q     (dl_out)
  );

  assign {r_wr_en, cache_wr_addr, r_wr_addr} = dl_out;

endmodule

`default_nettype wire
